mips_ifu: RTL and testbench
===========================

Name: mips_ifu

Overview:
- Instruction fetch unit. It sits at the producer end of the control decoder's interface.
- It fetches instruction words from instruction memory over a req/rvalid handshake and presents opcode/funct/rt plus a nop bubble flag to the decoder.
- It consumes the decoder's NPCOp to compute and register the next PC: sequential, branch, jump or exception vector.
- It records the EPC on exceptions and counts them.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, fetch address taken on NPC_EXCEPT or on an imem error.
- EXC_CNT_W, 8, width of the saturating exception counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request strobe, one cycle per fetch.
- imem_addr  output  32  word-aligned fetch address; equals pc.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- imem_err  input  1  bus error, qualified by imem_rvalid.
- exec_stall  input  1  holds the current instruction in EXEC.
- npc_op  input  3  decoder NPCOp: 0 PLUS4, 1 BRANCH, 2 JUMP, 3 EXCEPT; 4-7 are treated as EXCEPT.
- opcode  output  6  ir[31:26].
- funct  output  6  ir[5:0].
- rt  output  5  ir[20:16].
- instr  output  32  full instruction register.
- nop  output  1  1 = no valid instruction this cycle (bubble).
- pc  output  32  address of the instruction in instr.
- pc_plus4  output  32  pc + 4, used as the WDSel_FromPC source.
- epc  output  32  pc of the last excepting instruction.
- exc_cnt  output  EXC_CNT_W  exceptions taken, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - pc = RESET_PC.
  - instr = 0.
  - epc = 0.
  - exc_cnt = 0.
  - nop = 1.
  - imem_req = 0.
  - State = FETCH.
- State machine, FETCH:
  - imem_req = 1 for exactly one cycle with imem_addr = pc, then go to WAIT.
  - imem_rvalid seen in FETCH is ignored.
- State machine, WAIT:
  - imem_req = 0. Hold until imem_rvalid = 1.
  - On rvalid with imem_err = 0: instr <= imem_rdata, go to EXEC.
  - On rvalid with imem_err = 1: take the exception path with epc <= pc, instr unchanged, go to FETCH.
  - No timeout.
- State machine, EXEC:
  - nop = 0; this is the only state with nop = 0.
  - If exec_stall = 1: stay in EXEC and keep instr/pc stable.
  - Otherwise sample npc_op, load the next pc, and go to FETCH.
- Next-PC computation (32-bit, wrapping, no overflow detection):
  - PLUS4: pc + 4.
  - BRANCH: pc + 4 + (sign_extend(instr[15:0]) << 2).
  - JUMP: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - EXCEPT: EXC_VECTOR, with epc <= pc.
- Exception counter: exc_cnt increments on every exception (npc_op EXCEPT or imem_err) and saturates at all-ones.
- Throughput: minimum one instruction every 3 cycles (FETCH, WAIT with same-cycle-after rvalid, EXEC). The decoder output is sampled only on the EXEC exit edge.
- nop = 1 in FETCH/WAIT, so the decoder forces RFWr = 0. npc_op is ignored whenever nop = 1.
- pc wrap: 32'hFFFF_FFFC + 4 gives 0. No error is raised.
- Reset mid-operation: any state returns to FETCH at RESET_PC. Instruction memory shares rst_n, so no stale rvalid arrives after reset.
- Jump from 32'hFFFF_FFFC: pc_plus4 = 0, so the target upper bits are 4'h0.

Test Plan:
- Reset, then memory with 1-cycle latency returning ori (32'h3421_0005), npc_op = 0:
  - first imem_addr = 32'h0000_3000.
  - nop = 0 for one cycle with opcode = 6'h0D, rt = 1.
  - next fetch at 32'h0000_3004.
  - exc_cnt = 0.
- Branch at pc 32'h0000_3008, instr 32'h1000_FFFE (beq, offset -2), npc_op = 1:
  - next imem_addr = 32'h0000_3004.
  - With npc_op = 0 instead: 32'h0000_300C.
- Jump at pc 32'h0000_3010, instr 32'h0800_0C00, npc_op = 2:
  - next imem_addr = 32'h0000_3000.
- Undefined opcode at pc 32'h0000_3014, npc_op = 3:
  - next imem_addr = 32'h0000_4180.
  - epc = 32'h0000_3014.
  - exc_cnt = 1.
- Exception saturation, then a bus error:
  - 256 consecutive EXCEPTs leave exc_cnt at 8'hFF.
  - A further imem_err with rvalid at pc 32'h0000_4180 gives epc = 32'h0000_4180, next fetch at 32'h0000_4180, exc_cnt still 8'hFF.
- Stall and async reset:
  - exec_stall = 1 for 5 cycles in EXEC keeps nop = 0 and instr/pc stable, with no imem_req.
  - Dropping rst_n during WAIT at pc 32'h0000_3020 immediately gives nop = 1 and pc = 32'h0000_3000.
  - After release, the first imem_req is issued at 32'h0000_3000.

Source files
------------

// File: rtl/mips_ifu.sv
// Instruction fetch unit: fetches over a req/rvalid handshake, holds the
// instruction for the decoder and registers the next PC from its NPCOp.
module mips_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int unsigned EXC_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  input  logic                 imem_err,
  input  logic                 exec_stall,
  input  logic [2:0]           npc_op,
  output logic [5:0]           opcode,
  output logic [5:0]           funct,
  output logic [4:0]           rt,
  output logic [31:0]          instr,
  output logic                 nop,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic [31:0]          epc,
  output logic [EXC_CNT_W-1:0] exc_cnt
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2
  } npc_t;

  state_t                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic [31:0]           epc_q, epc_d;
  logic [EXC_CNT_W-1:0]  exc_cnt_q, exc_cnt_d;
  logic [31:0]           pc_next;
  logic                  take_exc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      epc_q     <= '0;
      exc_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      epc_q     <= epc_d;
      exc_cnt_q <= exc_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = WAIT;
      WAIT:    if (imem_rvalid) state_d = imem_err ? FETCH : EXEC;
      EXEC:    if (!exec_stall) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Request is masked during reset so it reads 0 while rst_n is low.
  always_comb begin
    imem_req = (state_q == FETCH) && rst_n;
    nop      = (state_q != EXEC);
  end

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_next  = EXC_VECTOR;
    take_exc = 1'b0;
    case (npc_op)
      NPC_PLUS4:  pc_next = pc_plus4;
      NPC_BRANCH: pc_next = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      NPC_JUMP:   pc_next = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      default:    take_exc = 1'b1;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    epc_d     = epc_q;
    exc_cnt_d = exc_cnt_q;
    if (state_q == WAIT && imem_rvalid) begin
      if (imem_err) begin
        pc_d  = EXC_VECTOR;
        epc_d = pc_q;
        if (exc_cnt_q != '1) exc_cnt_d = exc_cnt_q + 1'b1;
      end else begin
        instr_d = imem_rdata;
      end
    end else if (state_q == EXEC && !exec_stall) begin
      pc_d = pc_next;
      if (take_exc) begin
        epc_d = pc_q;
        if (exc_cnt_q != '1) exc_cnt_d = exc_cnt_q + 1'b1;
      end
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[31:26];
  assign funct     = instr_q[5:0];
  assign rt        = instr_q[20:16];
  assign epc       = epc_q;
  assign exc_cnt   = exc_cnt_q;

endmodule

// File: tb/tb_mips_ifu.sv
// Directed bench for mips_ifu with a one-cycle-latency instruction memory.
module tb_mips_ifu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        exec_stall;
  logic [2:0]  npc_op;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [31:0] instr;
  logic        nop;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic [7:0]  exc_cnt;

  int checks = 0;
  int errors = 0;

  mips_ifu #(.RESET_PC(32'h0000_3000), .EXC_VECTOR(32'h0000_4180), .EXC_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .exec_stall(exec_stall), .npc_op(npc_op),
    .opcode(opcode), .funct(funct), .rt(rt), .instr(instr), .nop(nop),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .exc_cnt(exc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the fetch strobe, check its address, then answer in WAIT.
  // Returns on the negedge after the response edge.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word, input logic err);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("imem_addr", imem_addr, exp_addr);
    @(negedge clk);
    chk("wait_req_low", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    imem_err    = err;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
  endtask

  // Fetch one instruction and hand the decoder's npc_op in EXEC.
  task automatic run(input logic [31:0] exp_addr, input logic [31:0] word, input logic [2:0] op);
    fetch(exp_addr, word, 1'b0);
    chk("exec_nop", {31'd0, nop}, 32'd0);
    npc_op = op;
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    imem_err    = 1'b0;
    exec_stall  = 1'b0;
    npc_op      = 3'd0;
    #12;
    chk("rst_nop", {31'd0, nop}, 32'd1);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cnt", {24'd0, exc_cnt}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // ori r1, r1, 5
    run(32'h0000_3000, 32'h3421_0005, 3'd0);
    chk("ori_opcode", {26'd0, opcode}, 32'h0D);
    chk("ori_rt", {27'd0, rt}, 32'd1);
    chk("ori_pc_plus4", pc_plus4, 32'h0000_3004);
    @(negedge clk);
    chk("one_cycle_nop", {31'd0, nop}, 32'd1);
    chk("ori_cnt", {24'd0, exc_cnt}, 32'd0);

    // beq offset -2 taken, then not taken
    run(32'h0000_3004, 32'h0000_0000, 3'd0);
    run(32'h0000_3008, 32'h1000_FFFE, 3'd1);
    run(32'h0000_3004, 32'h0000_0000, 3'd0);
    run(32'h0000_3008, 32'h1000_FFFE, 3'd0);
    run(32'h0000_300C, 32'h0000_0000, 3'd0);
    // j 0x3000
    run(32'h0000_3010, 32'h0800_0C00, 3'd2);
    run(32'h0000_3000, 32'h0000_0000, 3'd0);
    run(32'h0000_3004, 32'h0000_0000, 3'd0);
    run(32'h0000_3008, 32'h0000_0000, 3'd0);
    run(32'h0000_300C, 32'h0000_0000, 3'd0);
    run(32'h0000_3010, 32'h0000_0000, 3'd0);
    // undefined opcode -> exception
    run(32'h0000_3014, 32'hFC00_0000, 3'd3);
    @(negedge clk);
    chk("exc_epc", epc, 32'h0000_3014);
    chk("exc_cnt1", {24'd0, exc_cnt}, 32'd1);
    chk("exc_pc", pc, 32'h0000_4180);

    // 255 more exceptions (npc_op 7 aliases EXCEPT): 256 total
    for (int i = 0; i < 255; i++)
      run(32'h0000_4180, 32'hFC00_0000, (i % 2 == 0) ? 3'd3 : 3'd7);
    @(negedge clk);
    chk("sat_cnt", {24'd0, exc_cnt}, 32'hFF);

    // bus error at the vector: epc captured, instr unchanged, counter stays saturated
    fetch(32'h0000_4180, 32'h1234_5678, 1'b1);
    chk("err_nop", {31'd0, nop}, 32'd1);
    chk("err_epc", epc, 32'h0000_4180);
    chk("err_instr", instr, 32'hFC00_0000);
    chk("err_cnt", {24'd0, exc_cnt}, 32'hFF);

    // stall in EXEC
    run(32'h0000_4180, 32'h3421_0005, 3'd0);
    exec_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_nop", {31'd0, nop}, 32'd0);
      chk("stall_pc", pc, 32'h0000_4180);
      chk("stall_instr", instr, 32'h3421_0005);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    exec_stall = 1'b0;
    npc_op     = 3'd0;

    // j 0x3020 from 0x4184, then reset in WAIT
    run(32'h0000_4184, 32'h0800_0C08, 3'd2);
    @(negedge clk);
    chk("jmp_req", {31'd0, imem_req}, 32'd1);
    chk("jmp_addr", imem_addr, 32'h0000_3020);
    @(negedge clk);
    chk("in_wait_nop", {31'd0, nop}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_nop", {31'd0, nop}, 32'd1);
    chk("mid_rst_pc", pc, 32'h0000_3000);
    chk("mid_rst_cnt", {24'd0, exc_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0000_3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
